// File: rtl/multi_tap_delay_line_pkg.sv
// Shared types and width helpers for the multi-tap word delay line.
// Imported by the top and any bench that wants the default tap-array type.
package multi_tap_delay_line_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // Width of a field that must hold 0..block_length inclusive.
    function automatic int len_w(input int block_length);
        return $clog2(block_length + 1);
    endfunction

    function automatic int tap_w(input int block_length);
        return (block_length < 2) ? 1 : $clog2(block_length);
    endfunction

    localparam int DEF_BLOCK_LENGTH = 16;
    localparam int DEF_NUM_TAPS     = 4;
    localparam int DEF_TAP_W        = tap_w(DEF_BLOCK_LENGTH);

    typedef logic [DEF_NUM_TAPS-1:0][DEF_TAP_W-1:0] tap_idx_arr_t;

endpackage

// File: rtl/word_sel_mux.sv
// Gated word selector: picks one of BLOCK_LENGTH stored words, or zero when disabled.
// Indices outside the array also produce zero.
module word_sel_mux #(
    parameter int DATA_WIDTH   = 8,
    parameter int BLOCK_LENGTH = 16,
    parameter int SEL_W        = 4
) (
    input  logic [BLOCK_LENGTH-1:0][DATA_WIDTH-1:0] words,
    input  logic [SEL_W-1:0]                        sel,
    input  logic                                    en,
    output logic [DATA_WIDTH-1:0]                   word
);

    always_comb begin
        word = '0;
        if (en) begin
            for (int i = 0; i < BLOCK_LENGTH; i++) begin
                if (sel == SEL_W'(i)) word = words[i];
            end
        end
    end

endmodule

// File: rtl/multi_tap_delay_line.sv
// Word-wide delay line with programmable active length, tap points, per-output
// valid flags and a zero-filling flush drain. state_dbg exposes the FSM state.
module multi_tap_delay_line
    import multi_tap_delay_line_pkg::*;
#(
    parameter  int DATA_WIDTH   = 8,
    parameter  int BLOCK_LENGTH = 16,
    parameter  int NUM_TAPS     = 4,
    localparam int LEN_W        = len_w(BLOCK_LENGTH),
    localparam int TAP_W        = tap_w(BLOCK_LENGTH)
) (
    input  logic                                clk_in,
    input  logic                                rst_n,
    input  logic                                cfg_latch,
    input  logic [LEN_W-1:0]                    cfg_length,
    input  logic [NUM_TAPS-1:0][TAP_W-1:0]      cfg_taps,
    input  logic                                shift_en,
    input  logic [DATA_WIDTH-1:0]               d_in,
    input  logic                                flush,
    output logic [DATA_WIDTH-1:0]               d_out,
    output logic                                d_out_valid,
    output logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] tap_out,
    output logic [NUM_TAPS-1:0]                 tap_valid,
    output logic                                idle,
    output logic                                cfg_err,
    output state_t                              state_dbg
);

    logic [BLOCK_LENGTH-1:0][DATA_WIDTH-1:0] stage_q;
    logic [LEN_W-1:0]                        length_q;
    logic [NUM_TAPS-1:0][TAP_W-1:0]          taps_q;
    logic [LEN_W-1:0]                        fill_q, fill_d;
    state_t                                  state_q, state_d;
    logic                                    cfg_err_q;

    logic                  cfg_legal, cfg_take, cfg_reject, flush_take, do_shift;
    logic [LEN_W-1:0]      eff_length;
    logic [DATA_WIDTH-1:0] shift_word;

    always_comb begin
        cfg_legal = (cfg_length != '0) && (cfg_length <= LEN_W'(BLOCK_LENGTH));
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (LEN_W'(cfg_taps[k]) >= cfg_length) cfg_legal = 1'b0;
        end
        cfg_take   = cfg_latch && (state_q == ST_IDLE) && cfg_legal;
        cfg_reject = cfg_latch && !cfg_take;
        // A shift in the same cycle as an accepted config counts against the new length.
        eff_length = cfg_take ? cfg_length : length_q;
        flush_take = flush && ((state_q == ST_FILL) || (state_q == ST_FULL));
    end

    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        do_shift   = 1'b0;
        shift_word = d_in;
        case (state_q)
            ST_IDLE: begin
                if (shift_en) begin
                    do_shift = 1'b1;
                    fill_d   = LEN_W'(1);
                    state_d  = (eff_length == LEN_W'(1)) ? ST_FULL : ST_FILL;
                end
            end
            ST_FILL: begin
                if (flush_take) begin
                    state_d = ST_FLUSH;
                end else if (shift_en) begin
                    do_shift = 1'b1;
                    fill_d   = fill_q + LEN_W'(1);
                    if (fill_q + LEN_W'(1) == length_q) state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (flush_take) state_d = ST_FLUSH;
                else if (shift_en) do_shift = 1'b1;
            end
            ST_FLUSH: begin
                // Drain one word per cycle regardless of shift_en.
                do_shift   = 1'b1;
                shift_word = '0;
                if (fill_q <= LEN_W'(1)) begin
                    fill_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    fill_d = fill_q - LEN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                fill_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            stage_q   <= '0;
            length_q  <= LEN_W'(BLOCK_LENGTH);
            taps_q    <= '0;
            fill_q    <= '0;
            state_q   <= ST_IDLE;
            cfg_err_q <= 1'b0;
        end else begin
            if (do_shift) stage_q <= {stage_q[BLOCK_LENGTH-2:0], shift_word};
            if (cfg_take) begin
                length_q <= cfg_length;
                taps_q   <= cfg_taps;
            end
            fill_q    <= fill_d;
            state_q   <= state_d;
            cfg_err_q <= cfg_reject;
        end
    end

    assign d_out_valid = (state_q == ST_FULL);
    assign idle        = (state_q == ST_IDLE);
    assign cfg_err     = cfg_err_q;
    assign state_dbg   = state_q;

    word_sel_mux #(
        .DATA_WIDTH  (DATA_WIDTH),
        .BLOCK_LENGTH(BLOCK_LENGTH),
        .SEL_W       (TAP_W)
    ) u_dout_mux (
        .words(stage_q),
        .sel  (TAP_W'(length_q - LEN_W'(1))),
        .en   (d_out_valid),
        .word (d_out)
    );

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        assign tap_valid[k] = (fill_q > LEN_W'(taps_q[k]));

        word_sel_mux #(
            .DATA_WIDTH  (DATA_WIDTH),
            .BLOCK_LENGTH(BLOCK_LENGTH),
            .SEL_W       (TAP_W)
        ) u_tap_mux (
            .words(stage_q),
            .sel  (taps_q[k]),
            .en   (tap_valid[k]),
            .word (tap_out[k])
        );
    end

endmodule

// File: tb/tb_multi_tap_delay_line.sv
// Directed bench for multi_tap_delay_line: reset, fill, run, flush, config errors, length 1.
module tb_multi_tap_delay_line;
    import multi_tap_delay_line_pkg::*;

    logic             clk_in;
    logic             rst_n;
    logic             cfg_latch;
    logic [4:0]       cfg_length;
    tap_idx_arr_t     cfg_taps;
    logic             shift_en;
    logic [7:0]       d_in;
    logic             flush;
    logic [7:0]       d_out;
    logic             d_out_valid;
    logic [3:0][7:0]  tap_out;
    logic [3:0]       tap_valid;
    logic             idle;
    logic             cfg_err;
    state_t           state_dbg;

    int checks = 0;
    int errors = 0;

    multi_tap_delay_line #(
        .DATA_WIDTH  (8),
        .BLOCK_LENGTH(16),
        .NUM_TAPS    (4)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .cfg_latch  (cfg_latch),
        .cfg_length (cfg_length),
        .cfg_taps   (cfg_taps),
        .shift_en   (shift_en),
        .d_in       (d_in),
        .flush      (flush),
        .d_out      (d_out),
        .d_out_valid(d_out_valid),
        .tap_out    (tap_out),
        .tap_valid  (tap_valid),
        .idle       (idle),
        .cfg_err    (cfg_err),
        .state_dbg  (state_dbg)
    );

    // Clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
    endtask

    // Drivers: all inputs change just after a falling edge.
    task automatic drive_shift(input logic [7:0] w);
        shift_en = 1'b1;
        d_in     = w;
        @(negedge clk_in);
        shift_en = 1'b0;
        d_in     = '0;
    endtask

    task automatic drive_cfg(input logic [4:0] len, input tap_idx_arr_t taps);
        cfg_latch  = 1'b1;
        cfg_length = len;
        cfg_taps   = taps;
        @(negedge clk_in);
        cfg_latch  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({d_out, d_out_valid, tap_out, tap_valid, cfg_err} !== '0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got d_out=%h v=%b taps=%h tv=%b idle=%b err=%b required zeros idle=1",
                     d_out, d_out_valid, tap_out, tap_valid, idle, cfg_err);
        end
        drive_shift(8'hC1);
        drive_shift(8'hC2);
        drive_shift(8'hC3);
        checks++;
        if (tap_valid !== 4'b1111 || tap_out[0] !== 8'hC3) begin
            errors++;
            $display("FAIL pre_async_reset got tv=%b tap0=%h required 1111 c3", tap_valid, tap_out[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({d_out, d_out_valid, tap_out, tap_valid, cfg_err} !== '0 || idle !== 1'b1
            || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL async_reset got d_out=%h v=%b taps=%h tv=%b idle=%b required zeros idle=1",
                     d_out, d_out_valid, tap_out, tap_valid, idle);
        end
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_default_config();
        drive_shift(8'h01);
        checks++;
        if (tap_valid !== 4'b1111 || tap_out[3] !== 8'h01 || d_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL default_first_shift got tv=%b tap3=%h v=%b required 1111 01 0",
                     tap_valid, tap_out[3], d_out_valid);
        end
        for (int i = 2; i <= 15; i++) drive_shift(8'(i));
        checks++;
        if (d_out_valid !== 1'b0 || d_out !== 8'h00) begin
            errors++;
            $display("FAIL default_15_shifts got v=%b d_out=%h required 0 00", d_out_valid, d_out);
        end
        drive_shift(8'h10);
        checks++;
        if (d_out_valid !== 1'b1 || d_out !== 8'h01 || state_dbg !== ST_FULL) begin
            errors++;
            $display("FAIL default_16_shifts got v=%b d_out=%h st=%0d required 1 01 FULL",
                     d_out_valid, d_out, state_dbg);
        end
        do_reset();
    endtask

    task automatic test_configured_fill();
        logic [7:0] words  [0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [3:0] exp_tv [0:3] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        drive_cfg(5'd4, {4'd3, 4'd2, 4'd1, 4'd0});
        checks++;
        if (cfg_err !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL cfg_accept got err=%b idle=%b required 0 1", cfg_err, idle);
        end
        for (int i = 0; i < 4; i++) begin
            drive_shift(words[i]);
            checks++;
            if (tap_valid !== exp_tv[i] || d_out_valid !== (i == 3)) begin
                errors++;
                $display("FAIL fill_step%0d got tv=%b v=%b required %b %b",
                         i, tap_valid, d_out_valid, exp_tv[i], (i == 3));
            end
        end
        checks++;
        if (d_out !== 8'h11 || tap_out[0] !== 8'h44 || tap_out[3] !== 8'h11) begin
            errors++;
            $display("FAIL fill_data got d_out=%h tap0=%h tap3=%h required 11 44 11",
                     d_out, tap_out[0], tap_out[3]);
        end
    endtask

    task automatic test_continuous();
        drive_shift(8'h55);
        checks++;
        if (d_out !== 8'h22 || d_out_valid !== 1'b1 || tap_out[0] !== 8'h55) begin
            errors++;
            $display("FAIL run_shift got d_out=%h v=%b tap0=%h required 22 1 55",
                     d_out, d_out_valid, tap_out[0]);
        end
        repeat (3) @(negedge clk_in);
        checks++;
        if (d_out !== 8'h22 || d_out_valid !== 1'b1 || tap_out !== {8'h22, 8'h33, 8'h44, 8'h55}) begin
            errors++;
            $display("FAIL run_hold got d_out=%h v=%b taps=%h required 22 1 22334455",
                     d_out, d_out_valid, tap_out);
        end
    endtask

    task automatic test_flush();
        logic [3:0] exp_tv   [0:4] = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
        logic       exp_idle [0:4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       saw_99;
        flush    = 1'b1;
        shift_en = 1'b1;
        d_in     = 8'h99;
        @(negedge clk_in);
        flush = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk_in);
            if (c == 4) shift_en = 1'b0;
            saw_99 = (d_out === 8'h99);
            for (int k = 0; k < 4; k++) if (tap_out[k] === 8'h99) saw_99 = 1'b1;
            checks++;
            if (tap_valid !== exp_tv[c] || idle !== exp_idle[c] || d_out_valid !== 1'b0 || saw_99) begin
                errors++;
                $display("FAIL flush_cycle%0d got tv=%b idle=%b v=%b saw99=%b required %b %b 0 0",
                         c + 1, tap_valid, idle, d_out_valid, saw_99, exp_tv[c], exp_idle[c]);
            end
        end
        d_in = '0;
        flush = 1'b1;
        @(negedge clk_in);
        flush = 1'b0;
        checks++;
        if (idle !== 1'b1 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_idle got idle=%b err=%b required 1 0", idle, cfg_err);
        end
    endtask

    task automatic test_cfg_errors();
        logic [4:0]   bad_len  [0:2] = '{5'd0, 5'd17, 5'd4};
        tap_idx_arr_t bad_taps [0:2] = '{{4'd3, 4'd2, 4'd1, 4'd0},
                                         {4'd3, 4'd2, 4'd1, 4'd0},
                                         {4'd3, 4'd5, 4'd1, 4'd0}};
        for (int i = 0; i < 3; i++) begin
            drive_cfg(bad_len[i], bad_taps[i]);
            checks++;
            if (cfg_err !== 1'b1) begin
                errors++;
                $display("FAIL cfg_err_case%0d got %b required 1", i, cfg_err);
            end
            @(negedge clk_in);
            checks++;
            if (cfg_err !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_pulse%0d got %b required 0", i, cfg_err);
            end
        end
        drive_shift(8'hB1);
        drive_cfg(5'd2, '0);
        checks++;
        if (cfg_err !== 1'b1 || tap_valid !== 4'b0001) begin
            errors++;
            $display("FAIL cfg_in_fill got err=%b tv=%b required 1 0001", cfg_err, tap_valid);
        end
        drive_shift(8'hB2);
        drive_shift(8'hB3);
        checks++;
        if (d_out_valid !== 1'b0 || tap_valid !== 4'b0111) begin
            errors++;
            $display("FAIL cfg_kept_len got v=%b tv=%b required 0 0111", d_out_valid, tap_valid);
        end
        drive_shift(8'hB4);
        checks++;
        if (d_out_valid !== 1'b1 || d_out !== 8'hB1) begin
            errors++;
            $display("FAIL cfg_kept_full got v=%b d_out=%h required 1 b1", d_out_valid, d_out);
        end
        do_reset();
    endtask

    task automatic test_edge_length();
        cfg_latch  = 1'b1;
        cfg_length = 5'd1;
        cfg_taps   = '0;
        shift_en   = 1'b1;
        d_in       = 8'hA5;
        @(negedge clk_in);
        cfg_latch = 1'b0;
        shift_en  = 1'b0;
        checks++;
        if (d_out !== 8'hA5 || d_out_valid !== 1'b1 || state_dbg !== ST_FULL
            || cfg_err !== 1'b0 || tap_out[0] !== 8'hA5) begin
            errors++;
            $display("FAIL len1 got d_out=%h v=%b st=%0d err=%b tap0=%h required a5 1 FULL 0 a5",
                     d_out, d_out_valid, state_dbg, cfg_err, tap_out[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [0:2] = '{8'h5A, 8'h3C, 8'hE7};
        shift_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_in = words[i];
            @(negedge clk_in);
            checks++;
            if (d_out !== words[i] || d_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_word%0d got d_out=%h v=%b required %h 1",
                         i, d_out, d_out_valid, words[i]);
            end
        end
        shift_en = 1'b0;
        d_in     = '0;
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_latch  = 1'b0;
        cfg_length = '0;
        cfg_taps   = '0;
        shift_en   = 1'b0;
        d_in       = '0;
        flush      = 1'b0;
        test_reset();
        test_default_config();
        test_configured_fill();
        test_continuous();
        test_flush();
        test_cfg_errors();
        test_edge_length();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_tap_delay_line.md
Name: multi_tap_delay_line

Overview:
Parametrised word-wide delay line: DATA_WIDTH-bit words shift through up to BLOCK_LENGTH stages, with a runtime-programmable active length and NUM_TAPS programmable tap points.
- Adds over the single-bit tapped shift register: latched configuration, per-output valid flags, an explicit flush sequence and configuration-error reporting.
- Sits between a word source and downstream filters/correlators that need several delayed copies of one stream.

Parameters:
DATA_WIDTH, 8, bits per stored word
BLOCK_LENGTH, 16, maximum number of stages (>=2)
NUM_TAPS, 4, number of tap outputs (>=1)
LEN_W, $clog2(BLOCK_LENGTH+1), width of length/fill fields (derived, not overridden)
TAP_W, $clog2(BLOCK_LENGTH), width of tap index (derived)

Ports:
clk_in  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_latch  input  1  one-cycle request to load cfg_length/cfg_taps
cfg_length  input  LEN_W  requested active length, legal 1..BLOCK_LENGTH
cfg_taps  input  NUM_TAPS x TAP_W  requested tap stage indices, 0 = newest word
shift_en  input  1  shift d_in into stage 0 this cycle
d_in  input  DATA_WIDTH  input word
flush  input  1  one-cycle request to drain the line
d_out  output  DATA_WIDTH  stage[length-1]; 0 when d_out_valid low
d_out_valid  output  1  line full (fill_cnt == length)
tap_out  output  NUM_TAPS x DATA_WIDTH  stage[tap[k]]; 0 when tap_valid[k] low
tap_valid  output  NUM_TAPS  fill_cnt > tap[k]
idle  output  1  state == IDLE
cfg_err  output  1  one-cycle pulse on a rejected cfg_latch

Behaviour:
- Reset (async assert, sync release):
  - storage all 0; length = BLOCK_LENGTH; taps all 0; fill_cnt = 0; state IDLE.
  - Outputs: d_out = 0, d_out_valid = 0, tap_out = 0, tap_valid = 0, idle = 1, cfg_err = 0.
  - Reset mid-operation discards all contents and configuration.
- States: IDLE (fill_cnt = 0), FILL (0 < fill_cnt < length), FULL (fill_cnt == length), FLUSH.
- Shift: stage[0] <= d_in; stage[i] <= stage[i-1] for i = 1..BLOCK_LENGTH-1.
  - Stages at or beyond length still shift but are never observed.
- Output path:
  - Outputs are combinational muxes of registered storage, gated by their valid flags.
  - Word written at edge t appears on d_out after the length-th accepted shift, including the shift that stored it.
- fill_cnt: +1 per accepted shift, saturating at length.
- Transitions:
  - IDLE->FILL on shift_en; IDLE->FULL directly if length == 1.
  - FILL->FULL when fill_cnt reaches length.
  - FULL holds; further shifts keep fill_cnt = length and advance data.
  - FILL/FULL->FLUSH on flush.
- FLUSH:
  - Every cycle shifts in 0 and decrements fill_cnt; shift_en and d_in are ignored.
  - At fill_cnt = 0 -> IDLE. Drain takes exactly the entry fill_cnt cycles.
  - Valid flags track fill_cnt throughout the drain.
- Configuration:
  - Accepted only in IDLE.
  - Rejected (cfg_err pulse, config unchanged) if cfg_length == 0, cfg_length > BLOCK_LENGTH, any cfg_taps[k] >= cfg_length, or state != IDLE.
- Simultaneous events:
  - cfg_latch with shift_en in IDLE: new config takes effect and the shift is counted against the new length.
  - flush with shift_en: flush wins, d_in dropped.
  - flush in IDLE: no-op, no error.
- tap_valid[k] = (fill_cnt > tap[k]); d_out_valid = (state == FULL).

Decomposition:
- Package multi_tap_delay_line_pkg holds:
  - state enum (IDLE, FILL, FULL, FLUSH);
  - helper functions for LEN_W/TAP_W;
  - typedef for tap index array.
- Sub-module word_sel_mux: parametrised DATA_WIDTH x BLOCK_LENGTH -> 1 selector with gate enable.
  - One instance for d_out (index length-1), NUM_TAPS instances for taps (generate loop).

Test Plan:
- Reset defaults: assert rst_n = 0 mid-stream -> all outputs 0, idle = 1 immediately (async); after release, cfg_length = 16 and taps = 0 are in effect.
- Configured fill: cfg_length = 4, taps = {0,1,2,3}, shift words 0x11,0x22,0x33,0x44:
  - tap_valid rises 0001, 0011, 0111, 1111 on successive shifts;
  - after the 4th shift, d_out = 0x11, d_out_valid = 1, tap_out[0] = 0x44.
- Continuous run: with length 4 full, shift 0x55 -> d_out = 0x22 and d_out_valid stays 1; hold shift_en = 0 for 3 cycles -> outputs unchanged.
- Flush: in FULL with length 4, pulse flush together with shift_en (d_in = 0x99):
  - 0x99 never appears at any output;
  - d_out_valid drops next cycle;
  - idle = 1 exactly 4 cycles after flush.
- Config errors (each -> cfg_err pulse, config unchanged):
  - cfg_length = 0 in IDLE;
  - cfg_length = 17 in IDLE;
  - tap = 5 with cfg_length = 4;
  - any legal config while in FILL.
- Edge length: cfg_length = 1 with cfg_latch + shift_en (d_in = 0xA5) in the same cycle -> next cycle d_out = 0xA5, d_out_valid = 1, state FULL.
